video_tx_timing: RTL



---
 rtl/video_tx_timing.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/video_tx_timing.sv
// Raster timing generator and pixel serializer for the ADV7511 parallel bus.
// Optional colour-bar source is compiled in with `define VIDEO_TX_PATTERN_EN.
module video_tx_timing #(
    parameter int H_ACTIVE = 1920,
    parameter int H_FP     = 88,
    parameter int H_SYNC   = 44,
    parameter int H_BP     = 148,
    parameter int V_ACTIVE = 1080,
    parameter int V_FP     = 4,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 36,
    parameter int SYNC_POL = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic [23:0] pix_data_i,
    input  logic        pix_sof_i,
    input  logic        pix_valid_i,
    output logic        pix_ready_o,
`ifdef VIDEO_TX_PATTERN_EN
    input  logic        pattern_i,
`endif
    input  logic        clr_i,
    output logic        vout_hs_o,
    output logic        vout_vs_o,
    output logic        vout_de_o,
    output logic [23:0] vout_data_o,
    output logic        frame_start_o,
    output logic        underflow_o,
    output logic        misalign_o
);
    // state   | meaning
    // idle    | en_run = 0, counters parked at (0,0), outputs inactive
    // run     | en_run = 1, raster advancing; en_i re-sampled at frame end

    localparam int   H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int   V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int   HW       = $clog2(H_TOTAL);
    localparam int   VW       = $clog2(V_TOTAL);
    localparam logic SYNC_ACT = (SYNC_POL != 0);

    logic [HW-1:0] h_cnt, h_cnt_d;
    logic [VW-1:0] v_cnt, v_cnt_d;
    logic          en_run, en_run_d;
    logic          h_last, v_last, frame_end, at_origin, load_run;
    logic          active, act_run, hs_raw, vs_raw;
    logic          pat_on;
    logic [23:0]   pat_rgb, data_d;
    logic          uf_ev, mis_ev;

    assign h_last    = (h_cnt == HW'(H_TOTAL - 1));
    assign v_last    = (v_cnt == VW'(V_TOTAL - 1));
    assign frame_end = h_last && v_last;
    assign at_origin = (h_cnt == '0) && (v_cnt == '0);
    // en_i is taken at the frame boundary so the new value applies from (0,0) on
    assign load_run  = !en_run || frame_end;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            h_cnt  <= '0;
            v_cnt  <= '0;
            en_run <= 1'b0;
        end else begin
            h_cnt  <= h_cnt_d;
            v_cnt  <= v_cnt_d;
            en_run <= en_run_d;
        end
    end

    always_comb begin
        en_run_d = load_run ? en_i : en_run;
        h_cnt_d  = '0;
        v_cnt_d  = '0;
        if (en_run) begin
            h_cnt_d = h_last ? '0 : h_cnt + 1'b1;
            v_cnt_d = v_cnt;
            if (h_last)
                v_cnt_d = v_last ? '0 : v_cnt + 1'b1;
        end
    end

    assign active  = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
    assign act_run = active && en_run;
    assign hs_raw  = en_run && (h_cnt >= HW'(H_ACTIVE + H_FP))
                            && (h_cnt <  HW'(H_ACTIVE + H_FP + H_SYNC));
    assign vs_raw  = en_run && (v_cnt >= VW'(V_ACTIVE + V_FP))
                            && (v_cnt <  VW'(V_ACTIVE + V_FP + V_SYNC));

`ifdef VIDEO_TX_PATTERN_EN
    localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
    logic          pattern_q;
    logic [HW-1:0] bar_idx;
    logic [2:0]    bar;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            pattern_q <= 1'b0;
        else if (load_run)
            pattern_q <= pattern_i;
    end

    // bar order white..black maps to R=~b[1], G=~b[2], B=~b[0]
    always_comb begin
        bar_idx = h_cnt / HW'(BAR_W);
        bar     = (bar_idx > HW'(7)) ? 3'd7 : bar_idx[2:0];
        pat_rgb = {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}};
    end
    assign pat_on = pattern_q;
`else
    assign pat_on  = 1'b0;
    assign pat_rgb = 24'h000000;
`endif

    assign pix_ready_o = act_run && !pat_on;
    assign uf_ev       = act_run && !pat_on && !pix_valid_i;
    assign mis_ev      = pix_ready_o && pix_valid_i && (pix_sof_i != at_origin);

    always_comb begin
        data_d = 24'h000000;
        if (act_run) begin
            if (pat_on)
                data_d = pat_rgb;
            else if (pix_valid_i)
                data_d = pix_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vout_hs_o     <= ~SYNC_ACT;
            vout_vs_o     <= ~SYNC_ACT;
            vout_de_o     <= 1'b0;
            vout_data_o   <= 24'h000000;
            frame_start_o <= 1'b0;
            underflow_o   <= 1'b0;
            misalign_o    <= 1'b0;
        end else begin
            vout_hs_o     <= ~(hs_raw ^ SYNC_ACT);
            vout_vs_o     <= ~(vs_raw ^ SYNC_ACT);
            vout_de_o     <= act_run;
            vout_data_o   <= data_d;
            frame_start_o <= en_run && at_origin;
            underflow_o   <= uf_ev  || (underflow_o && !clr_i);
            misalign_o    <= mis_ev || (misalign_o  && !clr_i);
        end
    end
endmodule
